// File: rtl/mem_port_arbiter.sv
// Three-cycle (IDLE->ISSUE->DONE) arbiter sharing one synchronous single-port RAM
// between the program loader, CPU data port and CPU fetch port. Optional ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
  typedef enum logic [1:0] {W_IF, W_D, W_LD} win_t;

  state_t            state_q, state_d;
  win_t              win_q, win_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              pick_d;
  logic              done_rd;
  logic              unused_addr_bits;
`ifdef ARB_ROUND_ROBIN_EN
  logic              rr_q, rr_d;  // 1: data wins the next data/fetch tie
`endif

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d       = rr_q;
    pick_d     = d_req & (~if_req | rr_q);
`else
    pick_d     = d_req;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (ld_req | d_req | if_req) begin
          state_d = S_ISSUE;
          if (ld_req) begin
            win_d   = W_LD;
            addr_d  = ld_addr[ADDR_W+1:2];
            wdata_d = ld_wdata;
            we_d    = 1'b1;
          end else if (pick_d) begin
            win_d   = W_D;
            addr_d  = d_addr[ADDR_W+1:2];
            wdata_d = d_wdata;
            we_d    = d_we;
`ifdef ARB_ROUND_ROBIN_EN
            rr_d    = 1'b0;
`endif
          end else begin
            win_d   = W_IF;
            addr_d  = if_addr[ADDR_W+1:2];
            wdata_d = '0;
            we_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_d    = 1'b1;
`endif
          end
        end
      end
      S_ISSUE: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        if (!we_q && win_q == W_IF) if_rdata_d = mem_rdata;
        if (!we_q && win_q == W_D)  d_rdata_d  = mem_rdata;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      win_q      <= W_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q       <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

  always_comb begin
    done_rd   = (state_q == S_DONE) & ~we_q;
    mem_en    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_valid  = (state_q == S_DONE) & (win_q == W_IF);
    d_valid   = (state_q == S_DONE) & (win_q == W_D);
    ld_ack    = (state_q == S_DONE) & (win_q == W_LD);
    // Read data bypasses the holding register so it is valid alongside the pulse.
    if_rdata  = (done_rd && win_q == W_IF) ? mem_rdata : if_rdata_q;
    d_rdata   = (done_rd && win_q == W_D)  ? mem_rdata : d_rdata_q;
    cpu_stall = ld_req | (if_req & ~if_valid) | (d_req & ~d_valid);
    unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                         d_addr[1:0],  d_addr[31:ADDR_W+2],
                         ld_addr[1:0], ld_addr[31:ADDR_W+2]};
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model. Honours ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  localparam int AW = 14;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic if_req, d_req, d_we, ld_req;
  logic [31:0] if_addr, d_addr, d_wdata, ld_addr, ld_wdata;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic if_valid, d_valid, ld_ack, mem_en, mem_we, cpu_stall;
  logic [AW-1:0] mem_addr;

  bit [31:0] ram [NW];
  bit [31:0] ref_mem [NW];
  logic pre_we;
  logic [AW-1:0] pre_addr;
  logic [31:0] pre_data;

  int total = 0;
  int bad = 0;

  // model state: phase 0 idle / 1 issue / 2 done; winner 0=fetch 1=data 2=loader
  int m_phase, m_win, cyc, if_vcyc, d_vcyc, we4_cnt, stall_lo;
  int unsigned m_addr;
  logic [31:0] m_wdata, e_if_rd, e_d_rd;
  bit m_we, m_fav_d, v_if, v_d, v_ld, auto_drop;
  int grants[$];

  mem_port_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a >> 2) & (NW - 1);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = AW'($urandom_range(0, 15));
    return a;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_fav_d = 1'b1; e_if_rd = '0; e_d_rd = '0;
    v_if = 1'b0; v_d = 1'b0; v_ld = 1'b0;
  endtask

  task automatic check_cycle();
    int w;
    cyc++;
    v_if = (m_phase == 2 && m_win == 0);
    v_d  = (m_phase == 2 && m_win == 1);
    v_ld = (m_phase == 2 && m_win == 2);
    chk("mem_en", 32'(mem_en), 32'(m_phase == 1));
    chk("mem_we", 32'(mem_we), 32'(m_phase == 1 && m_we));
    if (m_phase == 1) begin
      chk("mem_addr", 32'(mem_addr), m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_valid", 32'(if_valid), 32'(v_if));
    chk("d_valid", 32'(d_valid), 32'(v_d));
    chk("ld_ack", 32'(ld_ack), 32'(v_ld));
    if (m_phase == 2 && !m_we) begin
      if (m_win == 0) e_if_rd = ref_mem[m_addr];
      if (m_win == 1) e_d_rd = ref_mem[m_addr];
    end
    chk("if_rdata", if_rdata, e_if_rd);
    chk("d_rdata", d_rdata, e_d_rd);
    chk("cpu_stall", 32'(cpu_stall), 32'(ld_req | (if_req & ~v_if) | (d_req & ~v_d)));
    if (v_if) if_vcyc = cyc;
    if (v_d) d_vcyc = cyc;
    if (mem_we && mem_addr == AW'(4)) we4_cnt++;
    if (!cpu_stall) stall_lo++;
    case (m_phase)
      0: if (ld_req || d_req || if_req) begin
        if (ld_req) w = 2;
`ifdef ARB_ROUND_ROBIN_EN
        else if (d_req && if_req) w = m_fav_d ? 1 : 0;
`endif
        else if (d_req) w = 1;
        else w = 0;
        if (w == 1) m_fav_d = 1'b0;
        if (w == 0) m_fav_d = 1'b1;
        m_win = w;
        grants.push_back(w);
        case (w)
          2: begin m_addr = word_of(ld_addr); m_wdata = ld_wdata; m_we = 1'b1; end
          1: begin m_addr = word_of(d_addr); m_wdata = d_wdata; m_we = d_we; end
          default: begin m_addr = word_of(if_addr); m_wdata = '0; m_we = 1'b0; end
        endcase
        m_phase = 1;
      end
      1: begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    if (auto_drop) begin
      if (v_if) if_req = 1'b0;
      if (v_d) d_req = 1'b0;
      if (v_ld) ld_req = 1'b0;
    end
  endtask

  // k: 0 fetch, 1 data, 2 loader, 3 fetch or data; always bounded by budget
  task automatic wait_valid(input int k, input int budget);
    int n;
    bit hit;
    n = 0;
    do begin
      run_cycle();
      n++;
      hit = (k == 0) ? v_if : (k == 1) ? v_d : (k == 2) ? v_ld : (v_if | v_d);
    end while (!hit && n < budget);
  endtask

  initial begin
    logic [31:0] saved;
    int first, second;
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; ld_req = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; ld_addr = '0; ld_wdata = '0;
    pre_we = 0; pre_addr = '0; pre_data = '0;
    auto_drop = 1'b1; cyc = 0; we4_cnt = 0; stall_lo = 0; if_vcyc = 0; d_vcyc = 0;
    m_win = 0; m_addr = 0; m_wdata = '0; m_we = 0;
    model_reset();

    @(posedge clk); #1;
    pre_we = 1; pre_addr = AW'(2); pre_data = 32'h0000_0013; ref_mem[2] = 32'h0000_0013;
    @(posedge clk); #1;
    pre_we = 0;
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_d_valid", 32'(d_valid), 0);
    chk("rst_ld_ack", 32'(ld_ack), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // first fetch right after reset release
    if_req = 1; if_addr = 32'h0000_0008;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0; grants.delete();
    wait_valid(0, 10);
    chk("fetch_valid_cycle", 32'(if_vcyc), 3);
    chk("fetch_rdata", if_rdata, 32'h0000_0013);

    // store then load at byte 0x10
    we4_cnt = 0;
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    wait_valid(1, 10);
    chk("store_keeps_d_rdata", d_rdata, 0);
    d_req = 1; d_we = 0;
    wait_valid(1, 10);
    chk("load_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("store_once", 32'(we4_cnt), 1);

    // simultaneous fetch and data
    grants.delete(); stall_lo = 0;
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h8;
`ifdef ARB_ROUND_ROBIN_EN
    first = 0; second = 1;
`else
    first = 1; second = 0;
`endif
    wait_valid(first, 12);
    wait_valid(second, 12);
    chk("tie_first", 32'(grants[0]), 32'(first));
    chk("tie_second", 32'(grants[1]), 32'(second));
    chk("tie_gap", 32'((first == 1) ? (if_vcyc - d_vcyc) : (d_vcyc - if_vcyc)), 3);
    chk("tie_stall_low_cycles", 32'(stall_lo), 1);
    chk("tie_if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("tie_d_rdata", d_rdata, 32'h0000_0013);

    // loader burst with both CPU requests held
    auto_drop = 1'b0; grants.delete();
    ld_req = 1; ld_addr = 32'h0; ld_wdata = 32'hA0;
    d_req = 1; d_we = 0; d_addr = 32'h0; if_req = 1; if_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      wait_valid(2, 12);
      ld_addr = ld_addr + 4; ld_wdata = ld_wdata + 1;
    end
    ld_req = 0;
    wait_valid(1, 12);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ld_grant%0d", k), 32'(grants[k]), 2);
      chk($sformatf("ld_ram%0d", k), ram[k], 32'hA0 + 32'(k));
    end
    chk("ld_then_data", 32'(grants[4]), 1);
    chk("ld_data_read", d_rdata, 32'hA0);

    // both CPU ports held over four accesses
    grants.delete();
    for (int k = 0; k < 4; k++) wait_valid(3, 12);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("held_grant%0d", k), 32'(grants[k]), 32'((k % 2 == 0) ? 0 : 1));
`else
      chk($sformatf("held_grant%0d", k), 32'(grants[k]), 1);
`endif
    end
    if_req = 0; d_req = 0; auto_drop = 1'b1;
    run_cycle();
    run_cycle();

    // randomized traffic with withdrawals
    for (int c = 0; c < 500; c++) begin
      run_cycle();
      if (!if_req) begin
        if ($urandom_range(0, 3) == 0) begin if_req = 1; if_addr = rand_addr(); end
      end else if (!(m_phase != 0 && m_win == 0) && $urandom_range(0, 15) == 0) if_req = 0;
      if (!d_req) begin
        if ($urandom_range(0, 3) == 0) begin
          d_req = 1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
        end
      end else if (!(m_phase != 0 && m_win == 1) && $urandom_range(0, 15) == 0) d_req = 0;
      if (!ld_req) begin
        if ($urandom_range(0, 15) == 0) begin ld_req = 1; ld_addr = rand_addr(); ld_wdata = $urandom; end
      end else if (!(m_phase != 0 && m_win == 2) && $urandom_range(0, 15) == 0) ld_req = 0;
    end
    if_req = 0; d_req = 0; ld_req = 0;
    for (int c = 0; c < 4; c++) run_cycle();

    // reset asserted during the ISSUE cycle of a store to 0x20
    saved = ram[8];
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55AA_33CC;
    run_cycle();
    chk("abort_pre_we", 32'(mem_we), 1);
    rst = 1'b1;
    #1;
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_mem_en", 32'(mem_en), 0);
    chk("abort_d_valid", 32'(d_valid), 0);
    chk("abort_mem_addr", 32'(mem_addr), 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_if_rdata", if_rdata, 0);
    chk("abort_d_rdata", d_rdata, 0);
    model_reset();
    d_req = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) run_cycle();
    chk("abort_ram_untouched", ram[8], saved);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
